// File: rtl/cpu_top.sv
// cpu_top: accumulator CPU with an 8-bit datapath, 6-bit addressing and a
// 64-word unified instruction/data memory (ADD, AND, JMP, INC).
// Optional feature macro: DEBUG_PORTS_EN adds pc_dbg, ac_dbg, ir_dbg and
// instr_done outputs; without it the port list is clk and resetn only.

module cpu_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] rdata
);
  // Contents are preloaded from outside; there is no store instruction,
  // and nothing here clears the array on reset.
  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  // Combinational read addressed by AR
  assign rdata = mem[addr];
endmodule

module cpu_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ac,
  output logic [1:0]        ir,
  output logic              done
);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_JMP = 2'b10;
  localparam logic [1:0] OP_INC = 2'b11;

  typedef enum logic [3:0] {
    FETCH1, FETCH2, FETCH3, ADD1, ADD2, AND1, AND2, JMP1, INC1
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pc_reg;
  logic [ADDR_W-1:0]   ar_reg;
  logic [DATA_W-1:0]   dr_reg;
  logic [1:0]          ir_reg;
  logic [DATA_W-1:0]   ac_reg;
  logic                done_reg;

  // One state per clock; done_reg is raised on entry to the final execute
  // state so it is high exactly during ADD2, AND2, JMP1 or INC1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= FETCH1;
      pc_reg   <= '0;
      ar_reg   <= '0;
      dr_reg   <= '0;
      ir_reg   <= '0;
      ac_reg   <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        FETCH1: begin
          ar_reg <= pc_reg;
          state  <= FETCH2;
        end
        FETCH2: begin
          dr_reg <= rdata;
          pc_reg <= pc_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
          state  <= FETCH3;
        end
        FETCH3: begin
          ir_reg <= dr_reg[DATA_W-1 -: 2];
          ar_reg <= dr_reg[ADDR_W-1:0];
          case (dr_reg[DATA_W-1 -: 2])
            OP_ADD: state <= ADD1;
            OP_AND: state <= AND1;
            OP_JMP: begin
              state    <= JMP1;
              done_reg <= 1'b1;
            end
            OP_INC: begin
              state    <= INC1;
              done_reg <= 1'b1;
            end
            default: state <= FETCH1;
          endcase
        end
        ADD1: begin
          dr_reg   <= rdata;
          done_reg <= 1'b1;
          state    <= ADD2;
        end
        ADD2: begin
          ac_reg <= ac_reg + dr_reg;
          state  <= FETCH1;
        end
        AND1: begin
          dr_reg   <= rdata;
          done_reg <= 1'b1;
          state    <= AND2;
        end
        AND2: begin
          ac_reg <= ac_reg & dr_reg;
          state  <= FETCH1;
        end
        JMP1: begin
          pc_reg <= dr_reg[ADDR_W-1:0];
          state  <= FETCH1;
        end
        INC1: begin
          ac_reg <= ac_reg + {{(DATA_W-1){1'b0}}, 1'b1};
          state  <= FETCH1;
        end
        default: state <= FETCH1;
      endcase
    end
  end

  assign addr = ar_reg;
  assign pc   = pc_reg;
  assign ac   = ac_reg;
  assign ir   = ir_reg;
  assign done = done_reg;
endmodule

module cpu_top #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              resetn
`ifdef DEBUG_PORTS_EN
  ,
  output logic [ADDR_W-1:0] pc_dbg,
  output logic [DATA_W-1:0] ac_dbg,
  output logic [1:0]        ir_dbg,
  output logic              instr_done
`endif
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] pc_w;
  logic [DATA_W-1:0] ac_w;
  logic [1:0]        ir_w;
  logic              done_w;

  cpu_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) memory1 (
    .addr  (mem_addr),
    .rdata (mem_rdata)
  );

  cpu_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) register1 (
    .clk    (clk),
    .resetn (resetn),
    .rdata  (mem_rdata),
    .addr   (mem_addr),
    .pc     (pc_w),
    .ac     (ac_w),
    .ir     (ir_w),
    .done   (done_w)
  );

`ifdef DEBUG_PORTS_EN
  assign pc_dbg     = pc_w;
  assign ac_dbg     = ac_w;
  assign ir_dbg     = ir_w;
  assign instr_done = done_w;
`else
  // Observation signals have no consumer without the debug ports.
  logic unused_dbg;
  assign unused_dbg = ^{pc_w, ac_w, ir_w, done_w};
`endif
endmodule

// File: tb/tb_cpu_top.sv
// Directed-vector bench for cpu_top: preloads programs through the memory1
// hierarchy and checks PC/AC at hand-computed clock edges.

module tb_cpu_top;
  logic clk;
  logic resetn;
  int   nvec;
  int   nmis;
  int   cyc;

`ifdef DEBUG_PORTS_EN
  logic [5:0] pc_dbg;
  logic [7:0] ac_dbg;
  logic [1:0] ir_dbg;
  logic       instr_done;
`endif

  cpu_top dut (
    .clk    (clk),
    .resetn (resetn)
`ifdef DEBUG_PORTS_EN
    ,
    .pc_dbg     (pc_dbg),
    .ac_dbg     (ac_dbg),
    .ir_dbg     (ir_dbg),
    .instr_done (instr_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Advance to the e-th rising edge after reset release, then settle 1 time unit.
  task automatic adv(input int e);
    while (cyc < e) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 64; i++) dut.memory1.mem[i] = 8'h00;
  endtask

  task automatic release_rst;
    @(negedge clk);
    resetn = 1'b1;
    cyc = 0;
  endtask

  logic [7:0] prog_a [0:12];
  logic [7:0] data_a [0:10];

  initial begin
    nvec = 0;
    nmis = 0;
    cyc  = 0;
    resetn = 1'b0;
    prog_a = '{8'hC0, 8'h21, 8'h22, 8'hC0, 8'hC0, 8'h87, 8'h24,
               8'h25, 8'h26, 8'h67, 8'h28, 8'h29, 8'h2A};
    data_a = '{8'h05, 8'h09, 8'h08, 8'h0A, 8'h10, 8'h02, 8'h02,
               8'h02, 8'h06, 8'h06, 8'h06};

    // Program A preloaded while reset is held
    repeat (2) @(posedge clk);
    clear_mem();
    for (int i = 0; i < 13; i++) dut.memory1.mem[i] = prog_a[i];
    for (int i = 0; i < 11; i++) dut.memory1.mem[32 + i] = data_a[i];
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", {2'b00, dut.register1.pc_reg}, 8'h00);
    chk("rst_ac", dut.register1.ac_reg, 8'h00);
    release_rst();
    chk("mem0_kept", dut.memory1.mem[0], 8'hC0);
    chk("mem33_kept", dut.memory1.mem[33], 8'h09);

    adv(3);  chk("inc_edge3", dut.register1.ac_reg, 8'h00);
    adv(4);  chk("inc_edge4", dut.register1.ac_reg, 8'h01);
    adv(8);  chk("add33_edge8", dut.register1.ac_reg, 8'h01);
    adv(9);  chk("add33_edge9", dut.register1.ac_reg, 8'h0A);
    adv(14); chk("add34", dut.register1.ac_reg, 8'h12);
    adv(18); chk("inc2", dut.register1.ac_reg, 8'h13);
    adv(22); chk("inc3", dut.register1.ac_reg, 8'h14);
    adv(26); chk("jmp7_pc", {2'b00, dut.register1.pc_reg}, 8'h07);
    chk("jmp7_ac", dut.register1.ac_reg, 8'h14);
    adv(31); chk("add37", dut.register1.ac_reg, 8'h16);
    adv(36); chk("add38", dut.register1.ac_reg, 8'h18);
    adv(41); chk("and39", dut.register1.ac_reg, 8'h00);
    adv(46); chk("add40", dut.register1.ac_reg, 8'h06);
    adv(51); chk("add41", dut.register1.ac_reg, 8'h0C);
    adv(56); chk("add42", dut.register1.ac_reg, 8'h12);
    chk("mem36_kept", dut.memory1.mem[36], 8'h10);

    // Program B: wrap cases for AC and PC
    @(negedge clk);
    resetn = 1'b0;
    clear_mem();
    dut.memory1.mem[0]  = 8'h28;  // ADD 40
    dut.memory1.mem[1]  = 8'hC0;  // INC
    dut.memory1.mem[2]  = 8'h29;  // ADD 41
    dut.memory1.mem[3]  = 8'h2A;  // ADD 42
    dut.memory1.mem[4]  = 8'hBF;  // JMP 63
    dut.memory1.mem[63] = 8'hC0;  // INC
    dut.memory1.mem[40] = 8'hFF;
    dut.memory1.mem[41] = 8'hF0;
    dut.memory1.mem[42] = 8'h20;
    @(posedge clk);
    #1;
    chk("rstB_ac", dut.register1.ac_reg, 8'h00);
    release_rst();
    adv(5);  chk("ac_ff", dut.register1.ac_reg, 8'hFF);
    adv(9);  chk("inc_wrap", dut.register1.ac_reg, 8'h00);
    adv(14); chk("ac_f0", dut.register1.ac_reg, 8'hF0);
    adv(19); chk("add_wrap", dut.register1.ac_reg, 8'h10);
    adv(23); chk("jmp63_pc", {2'b00, dut.register1.pc_reg}, 8'h3F);
    adv(24); chk("pc63_hold", {2'b00, dut.register1.pc_reg}, 8'h3F);
    adv(25); chk("pc_wrap0", {2'b00, dut.register1.pc_reg}, 8'h00);
    adv(27); chk("inc63", dut.register1.ac_reg, 8'h11);
    adv(32); chk("rerun_add40", dut.register1.ac_reg, 8'h10);

    // Reset asserted during ADD1 of the second instruction of program A
    @(negedge clk);
    resetn = 1'b0;
    clear_mem();
    for (int i = 0; i < 13; i++) dut.memory1.mem[i] = prog_a[i];
    for (int i = 0; i < 11; i++) dut.memory1.mem[32 + i] = data_a[i];
    @(posedge clk);
    release_rst();
    adv(7);
    chk("mid_pre_ac", dut.register1.ac_reg, 8'h01);
    chk("mid_pre_pc", {2'b00, dut.register1.pc_reg}, 8'h02);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_async_ac", dut.register1.ac_reg, 8'h00);
    chk("mid_async_pc", {2'b00, dut.register1.pc_reg}, 8'h00);
    release_rst();
    adv(3); chk("restart_edge3", dut.register1.ac_reg, 8'h00);
    adv(4); chk("restart_inc", dut.register1.ac_reg, 8'h01);
    adv(9); chk("restart_add33", dut.register1.ac_reg, 8'h0A);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
